// File: rtl/jt900h_shift_seq.sv
// jt900h_shift_seq: drives the one-bit ALU shift passes back-to-back to build
// multi-bit RLC/RRC/RL/RR/SLA/SRA/SLL/SRL at byte, word and long width.
module jt900h_shift_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        start,
    input  logic [2:0]  kind,
    input  logic [3:0]  cnt,
    input  logic        bs,
    input  logic        ws,
    input  logic        qs,
    input  logic [31:0] op,
    input  logic        cin,
    output logic [4:0]  alu_sel,
    output logic [2:0]  cx_sel,
    output logic        alu_cin,
    output logic [31:0] alu_op2,
    input  logic [31:0] alu_rslt,
    input  logic        alu_c,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_p,
    output logic        busy,
    output logic        done,
    output logic [31:0] rslt,
    output logic        c,
    output logic        n,
    output logic        z,
    output logic        p
);
    localparam logic [4:0] SHL_ALU = 5'd13;
    localparam logic [4:0] SHR_ALU = 5'd14;
    localparam logic [2:0] CIN_CX  = 3'd1;
    localparam logic [2:0] SH_CX   = 3'd2;
    localparam logic [2:0] SA_CX   = 3'd3;
    localparam logic [2:0] RLC = 3'd0, RRC = 3'd1, RL = 3'd2, RR = 3'd3, SRA = 3'd5;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      st;
    logic [31:0] acc;
    logic [4:0]  cnt_r;
    logic        cy;
    logic [2:0]  kind_r;
    logic        ws_r;
    logic        qs_r;
    logic [31:0] wmask;

    assign alu_op2 = acc;
    // bits above the operand width are cleared so rslt reads as zero-extended
    assign wmask   = {{16{qs_r}}, {8{ws_r | qs_r}}, 8'hff};

    always_comb begin
        alu_sel = st != RUN ? 5'd0 : kind_r[0] ? SHR_ALU : SHL_ALU;
        cx_sel  = st != RUN ? 3'd0 :
                  (kind_r == RLC || kind_r == SRA) ? SA_CX :
                  kind_r == RRC ? SH_CX : CIN_CX;
        alu_cin = st == RUN && (kind_r == RL || kind_r == RR) && cy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            rslt   <= 32'd0;
            {c, n, z, p} <= 4'd0;
            acc    <= 32'd0;
            cnt_r  <= 5'd0;
            cy     <= 1'b0;
            kind_r <= 3'd0;
            ws_r   <= 1'b0;
            qs_r   <= 1'b0;
        end else if (cen) begin
            done <= 1'b0;
            case (st)
                IDLE: if (start) begin
                    acc    <= op;
                    cnt_r  <= {cnt == 4'd0, cnt};
                    cy     <= cin;
                    kind_r <= kind;
                    ws_r   <= ws & ~bs;
                    qs_r   <= qs & ~bs & ~ws;
                    st     <= RUN;
                    busy   <= 1'b1;
                end
                RUN: begin
                    acc   <= alu_rslt;
                    cy    <= alu_c;
                    cnt_r <= cnt_r - 5'd1;
                    if (cnt_r == 5'd1) begin
                        st   <= IDLE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        rslt <= alu_rslt & wmask;
                        {c, n, z, p} <= {alu_c, alu_n, alu_z, alu_p};
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule
